// File: rtl/sent_tx_pkg.sv
// Shared types and constants for the SENT transmit frame path.
// Holds the sequencer state encoding and the SENT CRC4 lookup table.
package sent_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_STATUS,
    ST_DATA,
    ST_CRC,
    ST_PAUSE
  } state_t;

  // T[0] in the low nibble: {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}
  localparam logic [63:0] CRC4_TABLE = 64'h582FB6C1493EA7D0;
  localparam logic [3:0] CRC_SEED_DEFAULT = 4'h5;
  localparam int MAX_NIBBLES = 6;

  function automatic logic [3:0] crc4_lut(input logic [3:0] c);
    return CRC4_TABLE[{c, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sent_crc4.sv
// One SENT CRC4 nibble step plus the zero-nibble augmentation step.
// Purely combinational so the RX checker can share it.
module sent_crc4
  import sent_tx_pkg::*;
(
  input  logic [3:0] c_in,
  input  logic [3:0] d,
  output logic [3:0] c_next,
  output logic [3:0] c_final
);

  assign c_final = crc4_lut(c_in);
  assign c_next  = c_final ^ d;

endmodule

// File: rtl/sent_tx_frame_ctrl.sv
// SENT transmit frame sequencer: sync, status, data, CRC, pause.
// Drives the pulse generator and folds the CRC in while nibbles go out.
module sent_tx_frame_ctrl
  import sent_tx_pkg::*;
#(
  parameter int         NUM_DATA_NIBBLES = 6,
  parameter bit         PAUSE_EN         = 1'b1,
  parameter logic [3:0] CRC_SEED         = CRC_SEED_DEFAULT
) (
  input  logic                          clk_tx,
  input  logic                          reset_tx,
  input  logic                          frame_req_i,
  input  logic [3:0]                    status_i,
  input  logic [4*NUM_DATA_NIBBLES-1:0] data_i,
  input  logic                          abort_i,
  output logic                          frame_ack_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          sync_o,
  output logic                          pulse_o,
  output logic                          pause_o,
  output logic                          idle_o,
  output logic [3:0]                    nibble_o,
  input  logic                          pulse_done_i
);

  localparam int W  = 4 * NUM_DATA_NIBBLES;
  localparam int IW = $clog2(MAX_NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NUM_DATA_NIBBLES - 1);

  state_t        st_q, st_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    stat_q, stat_d;
  logic [3:0]    crc_q, crc_d;
  logic [W-1:0]  sr_q, sr_d, sr_shift;
  logic          abort_q, abort_d;
  logic          start, eof;
  logic          ack_d, done_d;
  logic [3:0]    crc_din, crc_next, crc_final;
  logic [3:0]    nibble_d;

  // Data leaves MSB nibble first, so a left shift exposes the next one.
  assign sr_shift = sr_q << 4;
  assign crc_din  = (st_q == ST_STATUS) ? sr_q[W-1 -: 4]
                                        : sr_shift[W-1 -: 4];

  sent_crc4 u_crc (
    .c_in   (crc_q),
    .d      (crc_din),
    .c_next (crc_next),
    .c_final(crc_final)
  );

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    stat_d  = stat_q;
    sr_d    = sr_q;
    crc_d   = crc_q;
    abort_d = abort_q | (abort_i & (st_q != ST_IDLE));
    start   = 1'b0;
    eof     = 1'b0;
    ack_d   = 1'b0;
    done_d  = 1'b0;

    if (st_q == ST_IDLE) begin
      start = frame_req_i;
    end else if (pulse_done_i) begin
      if (abort_d) begin
        st_d    = ST_IDLE;
        abort_d = 1'b0;
      end else begin
        case (st_q)
          ST_SYNC: st_d = ST_STATUS;
          ST_STATUS: begin
            st_d  = ST_DATA;
            idx_d = '0;
            crc_d = crc_next;
          end
          ST_DATA: begin
            if (idx_q == LAST) begin
              st_d  = ST_CRC;
              crc_d = crc_final;
            end else begin
              idx_d = idx_q + 1'b1;
              sr_d  = sr_shift;
              crc_d = crc_next;
            end
          end
          ST_CRC: begin
            if (PAUSE_EN) st_d = ST_PAUSE;
            else eof = 1'b1;
          end
          ST_PAUSE: eof = 1'b1;
          default: st_d = ST_IDLE;
        endcase
      end
    end

    if (eof) begin
      done_d = 1'b1;
      st_d   = ST_IDLE;
      start  = frame_req_i;
    end

    if (start) begin
      st_d   = ST_SYNC;
      idx_d  = '0;
      stat_d = status_i;
      sr_d   = data_i;
      crc_d  = CRC_SEED;
      ack_d  = 1'b1;
    end

    nibble_d = 4'h0;
    unique case (1'b1)
      st_d == ST_STATUS: nibble_d = stat_d;
      st_d == ST_DATA:   nibble_d = sr_d[W-1 -: 4];
      st_d == ST_CRC:    nibble_d = crc_d;
      default:           nibble_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk_tx or posedge reset_tx) begin
    if (reset_tx) begin
      st_q         <= ST_IDLE;
      idx_q        <= '0;
      stat_q       <= '0;
      sr_q         <= '0;
      crc_q        <= CRC_SEED;
      abort_q      <= 1'b0;
      frame_ack_o  <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      sync_o       <= 1'b0;
      pulse_o      <= 1'b0;
      pause_o      <= 1'b0;
      idle_o       <= 1'b1;
      nibble_o     <= 4'h0;
    end else begin
      st_q         <= st_d;
      idx_q        <= idx_d;
      stat_q       <= stat_d;
      sr_q         <= sr_d;
      crc_q        <= crc_d;
      abort_q      <= abort_d;
      frame_ack_o  <= ack_d;
      busy_o       <= (st_d != ST_IDLE);
      frame_done_o <= done_d;
      sync_o       <= (st_d == ST_SYNC);
      pulse_o      <= (st_d == ST_STATUS) || (st_d == ST_DATA) ||
                      (st_d == ST_CRC);
      pause_o      <= (st_d == ST_PAUSE);
      idle_o       <= (st_d == ST_IDLE);
      nibble_o     <= nibble_d;
    end
  end

endmodule

// File: tb/tb_sent_tx_frame_ctrl.sv
// Bench for sent_tx_frame_ctrl: frame-list reference model, per-cycle
// compare, directed frames with literal nibble sequences, random traffic.
module tb_sent_tx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  status = 4'h0;
  logic [23:0] data = 24'h0;
  logic        abort = 1'b0;
  logic        pd = 1'b0;

  logic       frame_ack_o, busy_o, frame_done_o;
  logic       sync_o, pulse_o, pause_o, idle_o;
  logic [3:0] nibble_o;
  logic [10:0] dut_vec;

  always #5 clk = ~clk;

  sent_tx_frame_ctrl #(
    .NUM_DATA_NIBBLES(6),
    .PAUSE_EN        (1'b1),
    .CRC_SEED        (4'h5)
  ) dut (
    .clk_tx      (clk),
    .reset_tx    (rst),
    .frame_req_i (req),
    .status_i    (status),
    .data_i      (data),
    .abort_i     (abort),
    .frame_ack_o (frame_ack_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o),
    .sync_o      (sync_o),
    .pulse_o     (pulse_o),
    .pause_o     (pause_o),
    .idle_o      (idle_o),
    .nibble_o    (nibble_o),
    .pulse_done_i(pd)
  );

  assign dut_vec = {frame_ack_o, busy_o, frame_done_o, sync_o,
                    pulse_o, pause_o, idle_o, nibble_o};

  localparam logic [3:0] T [16] = '{4'd0, 4'd13, 4'd7, 4'd10,
                                    4'd14, 4'd3, 4'd9, 4'd4,
                                    4'd1, 4'd12, 4'd6, 4'd11,
                                    4'd15, 4'd2, 4'd8, 4'd5};
  localparam int K_SYNC = 0, K_PULSE = 1, K_PAUSE = 2;
  localparam int M_LEN = 10;
  localparam logic [10:0] RESET_VEC = 11'h010;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a list of pulses walked by pulse_done.
  bit         m_active, m_abort, exp_ack, exp_done;
  int         m_pos;
  int         m_kind [M_LEN];
  logic [3:0] m_nib  [M_LEN];

  logic [3:0] log_q [$];
  int ack_cnt, done_cnt, both_cnt;
  bit last_ack;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, expected event not seen", name);
  endtask

  function automatic logic [3:0] crc_of(input logic [23:0] d);
    logic [3:0] c;
    c = 4'h5;
    for (int i = 0; i < 6; i++) c = T[c] ^ d[23 - 4*i -: 4];
    return T[c];
  endfunction

  task automatic load(input logic [3:0] s, input logic [23:0] d);
    m_kind[0] = K_SYNC;  m_nib[0] = 4'h0;
    m_kind[1] = K_PULSE; m_nib[1] = s;
    for (int i = 0; i < 6; i++) begin
      m_kind[2+i] = K_PULSE;
      m_nib[2+i]  = d[23 - 4*i -: 4];
    end
    m_kind[8] = K_PULSE; m_nib[8] = crc_of(d);
    m_kind[9] = K_PAUSE; m_nib[9] = 4'h0;
    m_pos = 0;
  endtask

  function automatic logic [10:0] exp_vec();
    logic s, p, z;
    s = m_active && (m_kind[m_pos] == K_SYNC);
    p = m_active && (m_kind[m_pos] == K_PULSE);
    z = m_active && (m_kind[m_pos] == K_PAUSE);
    return {exp_ack, m_active, exp_done, s, p, z, !m_active,
            m_active ? m_nib[m_pos] : 4'h0};
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_active = 0; m_abort = 0; m_pos = 0;
      exp_ack = 0; exp_done = 0;
    end else begin
      exp_ack = 0;
      exp_done = 0;
      if (!m_active) begin
        if (req) begin
          load(status, data);
          m_active = 1;
          exp_ack = 1;
        end
      end else begin
        if (abort) m_abort = 1;
        if (pd) begin
          if (m_abort) begin
            m_active = 0;
            m_abort = 0;
          end else if (m_pos == M_LEN - 1) begin
            exp_done = 1;
            if (req) begin
              load(status, data);
              exp_ack = 1;
            end else begin
              m_active = 0;
            end
          end else begin
            m_pos++;
          end
        end
      end
    end
  end

  // Pulse generator stand-in: random 1-cycle completions.
  initial forever begin
    @(posedge clk);
    #1 pd = ($urandom_range(0, 2) == 0);
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("outputs", 32'(dut_vec), 32'(exp_vec()));
      if (pulse_o && pd) log_q.push_back(nibble_o);
      if (frame_ack_o) ack_cnt++;
      if (frame_done_o) done_cnt++;
      if (frame_ack_o && frame_done_o) both_cnt++;
      last_ack = frame_ack_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    ack_cnt = 0; done_cnt = 0; both_cnt = 0;
  endtask

  function automatic logic [31:0] pack_log(input int off);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 8; i++)
      if (off + i < log_q.size()) v = {v[27:0], log_q[off+i]};
      else v = {v[27:0], 4'hX};
    return v;
  endfunction

  task automatic wait_inactive(input string name);
    int k;
    k = 0;
    while (m_active && k < 3000) begin
      step();
      k++;
    end
    if (m_active) expire(name);
    step();
    step();
  endtask

  task automatic run_frame(input logic [3:0] s, input logic [23:0] d,
                           input string name);
    clear_log();
    status = s;
    data = d;
    req = 1;
    step();
    req = 0;
    wait_inactive(name);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_vec", 32'(dut_vec), 32'(RESET_VEC));
    #1 rst = 0;
    repeat (12) step();
    chk("idle_ignores_pd", {30'h0, busy_o, idle_o}, 32'h1);

    chk("model_crc_zero", 32'(crc_of(24'h000000)), 32'h5);
    chk("model_crc_123456", 32'(crc_of(24'h123456)), 32'h2);
    chk("model_crc_abcdef", 32'(crc_of(24'hABCDEF)), 32'h7);

    run_frame(4'h3, 24'h000000, "frame_zero");
    chk("zero_len", log_q.size(), 8);
    chk("zero_nibbles", pack_log(0), 32'h30000005);
    chk("zero_acks", ack_cnt, 1);
    chk("zero_dones", done_cnt, 1);

    run_frame(4'h0, 24'h123456, "frame_123456");
    chk("inc_nibbles", pack_log(0), 32'h01234562);
    chk("inc_dones", done_cnt, 1);

    clear_log();
    status = 4'h9;
    data = 24'hABCDEF;
    req = 1;
    step();
    k = 0;
    while (done_cnt < 1 && k < 3000) begin
      step();
      k++;
    end
    if (done_cnt < 1) expire("b2b_first_done");
    req = 0;
    wait_inactive("b2b_end");
    chk("b2b_first", pack_log(0), 32'h9ABCDEF7);
    chk("b2b_second", pack_log(8), 32'h9ABCDEF7);
    chk("b2b_coincide", both_cnt, 1);
    chk("b2b_acks", ack_cnt, 2);
    chk("b2b_dones", done_cnt, 2);

    clear_log();
    status = 4'h1;
    data = 24'h654321;
    req = 1;
    step();
    req = 0;
    k = 0;
    while (log_q.size() < 3 && k < 3000) begin
      step();
      k++;
    end
    if (log_q.size() < 3) expire("abort_reach_idx2");
    abort = 1;
    step();
    abort = 0;
    wait_inactive("abort_end");
    chk("abort_no_done", done_cnt, 0);
    chk("abort_len", log_q.size(), 4);
    chk("abort_last_nib", (log_q.size() > 3) ? 32'(log_q[3]) : 32'hFFFF,
        32'h4);
    chk("abort_idle", {30'h0, busy_o, idle_o}, 32'h1);
    run_frame(4'h2, 24'h123456, "after_abort");
    chk("after_abort_nib", pack_log(0), 32'h21234562);
    chk("after_abort_done", done_cnt, 1);

    clear_log();
    status = 4'h3;
    data = 24'h000000;
    req = 1;
    step();
    req = 0;
    k = 0;
    while (!(m_active && m_pos == 8) && k < 3000) begin
      step();
      k++;
    end
    if (!(m_active && m_pos == 8)) expire("reach_crc");
    @(negedge clk);
    #2 rst = 1;
    #1 chk("reset_in_crc", 32'(dut_vec), 32'(RESET_VEC));
    repeat (2) @(negedge clk);
    #1 rst = 0;
    chk("reset_no_done", done_cnt, 0);
    run_frame(4'h5, 24'h123456, "after_reset");
    chk("after_reset_nib", pack_log(0), 32'h51234562);

    for (int c = 0; c < 4000; c++) begin
      step();
      abort = ($urandom_range(0, 29) == 0);
      if (!req) begin
        if ($urandom_range(0, 3) == 0) begin
          req = 1;
          status = 4'($urandom);
          data = 24'($urandom);
        end
      end else if (last_ack) begin
        case ($urandom_range(0, 2))
          0: req = 0;
          1: begin
            status = 4'($urandom);
            data = 24'($urandom);
          end
          default: ;
        endcase
      end
    end
    req = 0;
    abort = 0;
    wait_inactive("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
